// File: rtl/modexp_engine.sv
// ---------------------------------------------------------------------------
// modexp_engine
//
// Purpose:
//   Computes result = base^exponent mod modulus with a right-to-left binary
//   square-and-multiply sequencer. Each modular multiply is an interleaved
//   shift-add (MSB first over the multiplier) that takes exactly WIDTH
//   cycles, so no wide product is ever formed.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous reset, active low
//   start    in   request a new exponentiation (accepted only in IDLE)
//   base     in   WIDTH      operand, captured on accepted start
//   exponent in   EXP_WIDTH  exponent, captured on accepted start
//   modulus  in   WIDTH      modulus n, captured on accepted start
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse in DONE
//   error    out  operands illegal (modulus<2 or base>=modulus); valid with done
//   result   out  WIDTH      final value, held until the next run completes
// ---------------------------------------------------------------------------
module modexp_engine #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_SQR  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    logic [2:0]           state;
    logic [WIDTH-1:0]     b_r;
    logic [EXP_WIDTH-1:0] e_r;
    logic [WIDTH-1:0]     n_r;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     sq;
    logic [WIDTH-1:0]     p;
    logic [CW-1:0]        cnt;

    logic                 x_bit;
    logic [WIDTH-1:0]     t_next;
    logic [EXP_WIDTH-1:0] e_sh;

    // One interleaved step: p' = (2p + bit*y) mod n, given p, y < n.
    // Intermediates are WIDTH+1 bits wide; both partial sums stay below 2n.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] pv,
        input logic             bit_i,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] nn;
        nn = {1'b0, n};
        t  = {pv, 1'b0};
        if (t >= nn) t = t - nn;
        if (bit_i) begin
            t = t + {1'b0, y};
            if (t >= nn) t = t - nn;
        end
        return t[WIDTH-1:0];
    endfunction

    // MUL scans acc against sq; SQR scans sq against itself. The multiplicand
    // is sq in both cases, so only the scanned bit needs selecting.
    always_comb begin
        x_bit  = (state == S_MUL) ? acc[cnt] : sq[cnt];
        t_next = mod_step(p, x_bit, sq, n_r);
        e_sh   = e_r >> 1;
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            b_r    <= '0;
            e_r    <= '0;
            n_r    <= '0;
            acc    <= '0;
            sq     <= '0;
            p      <= '0;
            cnt    <= '0;
            error  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        b_r   <= base;
                        e_r   <= exponent;
                        n_r   <= modulus;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    p   <= '0;
                    cnt <= CNT_TOP;
                    if ((n_r < WIDTH'(2)) || (b_r >= n_r)) begin
                        error  <= 1'b1;
                        result <= '0;
                        state  <= S_DONE;
                    end else if (e_r == '0) begin
                        error  <= 1'b0;
                        result <= WIDTH'(1);
                        state  <= S_DONE;
                    end else begin
                        acc   <= WIDTH'(1);
                        sq    <= b_r;
                        state <= e_r[0] ? S_MUL : S_SQR;
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        acc <= t_next;
                        p   <= '0;
                        cnt <= CNT_TOP;
                        // No higher exponent bits left: the final square is useless.
                        if (e_sh == '0) begin
                            result <= t_next;
                            error  <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            state <= S_SQR;
                        end
                    end else begin
                        p   <= t_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SQR: begin
                    if (cnt == '0) begin
                        sq    <= t_next;
                        p     <= '0;
                        cnt   <= CNT_TOP;
                        e_r   <= e_sh;
                        // SQR is entered only while higher bits remain, so e_sh != 0.
                        state <= e_sh[0] ? S_MUL : S_SQR;
                    end else begin
                        p   <= t_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
